counter_x: RTL

- Three-channel 32-bit down-counter peripheral. It is the bus responder behind the 0xF000_0004 counter window of the memory-mapped I/O decoder.
- Inputs from the decoder: counter_we and the write data.
- Outputs to the decoder:
  - counter_out, the read data.
  - counter0_out..counter2_out, status flags read back through the 0xF000_0000 GPIO word.
- Channel/control selection comes from counter_set, which the GPIO port register drives.

---
 rtl/counter_x.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/counter_x.sv
// counter_x: three 32-bit down-counter channels plus a 9-bit control word behind one bus window.
// Latency: writes land on the next clk edge; counter_out is a combinational mux (zero latency).
// Backpressure: none; every counter_we strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst        - system clock; synchronous active-high reset
//   counter_we      - single-cycle write strobe from the I/O decoder
//   counter_set     - target select: 0..2 channel, 3 control word
//   Peripheral_in   - write data
//   counter_out     - live value of the selected target
//   counter0_out..counter2_out - per-channel status flags
module counter_x #(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CH_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            counter_we,
    input  logic [1:0]      counter_set,
    input  logic [CH_W-1:0] Peripheral_in,
    output logic [CH_W-1:0] counter_out,
    output logic            counter0_out,
    output logic            counter1_out,
    output logic            counter2_out
);

    typedef enum logic [1:0] {
        MODE_ONESHOT     = 2'b00,
        MODE_PERIODIC    = 2'b01,
        MODE_SQUARE      = 2'b10,
        MODE_ONESHOT_ALT = 2'b11
    } mode_e;

    localparam int unsigned     NUM_CH  = 3;
    localparam int unsigned     CTRL_W  = 3 * NUM_CH;
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CH_W-1:0] ONE     = CH_W'(1);

    // Prescaler and control word
    logic [PS_W-1:0]   r_presc;
    logic              w_tick;
    logic [CTRL_W-1:0] r_ctrl;
    logic              w_ctrl_wr;

    // Channel state
    logic [CH_W-1:0]   r_count  [NUM_CH];
    logic [CH_W-1:0]   r_reload [NUM_CH];
    logic [NUM_CH-1:0] r_out;
    // Marks a status bit that was raised as a periodic pulse; such a bit
    // drops on the following edge whatever the tick or enable state.
    logic [NUM_CH-1:0] r_pulse;

    // Next-state from the per-channel logic
    logic [CH_W-1:0]   w_count_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_out_nxt;
    logic [NUM_CH-1:0] w_pulse_nxt;
    logic [NUM_CH-1:0] w_ch_wr;

    assign w_tick    = (r_presc == PS_LAST);
    assign w_ctrl_wr = counter_we && (counter_set == 2'd3);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic            w_en;
        mode_e           w_mode;
        logic [CH_W-1:0] w_cnt_n;
        logic            w_out_n;
        logic            w_pulse_n;

        assign w_ch_wr[g] = counter_we && (counter_set == 2'(g));
        assign w_en       = r_ctrl[3*g];
        assign w_mode     = mode_e'(r_ctrl[3*g+1 +: 2]);

        always_comb begin
            w_cnt_n   = r_count[g];
            w_out_n   = r_out[g];
            w_pulse_n = 1'b0;
            if (w_ch_wr[g]) begin
                // A bus write wins over a tick landing on the same edge.
                w_cnt_n = Peripheral_in;
                w_out_n = 1'b0;
            end else begin
                if (r_pulse[g]) begin
                    w_out_n = 1'b0;
                end
                if (w_tick && w_en) begin
                    // Every mode simply counts down while above 1; the
                    // modes only differ in what happens at the bottom.
                    if (r_count[g] > ONE) begin
                        w_cnt_n = r_count[g] - ONE;
                    end else begin
                        case (w_mode)
                            MODE_PERIODIC: begin
                                // Reaching 0 by other means (mode switch)
                                // reloads silently without a pulse.
                                w_cnt_n = r_reload[g];
                                if (r_count[g] == ONE) begin
                                    w_out_n   = 1'b1;
                                    w_pulse_n = 1'b1;
                                end
                            end
                            MODE_SQUARE: begin
                                w_cnt_n = r_reload[g];
                                if (r_reload[g] != '0) begin
                                    w_out_n = ~r_out[g];
                                end
                            end
                            default: begin
                                // One-shot: expire once at 1, then hold 0
                                // with the flag latched until rewritten.
                                if (r_count[g] == ONE) begin
                                    w_cnt_n = '0;
                                    w_out_n = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
        end

        assign w_count_nxt[g] = w_cnt_n;
        assign w_out_nxt[g]   = w_out_n;
        assign w_pulse_nxt[g] = w_pulse_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_ctrl  <= '0;
            r_out   <= '0;
            r_pulse <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_count[i]  <= '0;
                r_reload[i] <= '0;
            end
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            // Upper write-data bits have no meaning for the control word.
            if (w_ctrl_wr) begin
                r_ctrl <= Peripheral_in[CTRL_W-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_count[i] <= w_count_nxt[i];
                if (w_ch_wr[i]) begin
                    r_reload[i] <= Peripheral_in;
                end
            end
            r_out   <= w_out_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        case (counter_set)
            2'd0:    counter_out = r_count[0];
            2'd1:    counter_out = r_count[1];
            2'd2:    counter_out = r_count[2];
            default: counter_out = CH_W'(r_ctrl);
        endcase
    end

    assign counter0_out = r_out[0];
    assign counter1_out = r_out[1];
    assign counter2_out = r_out[2];

endmodule
